// File: rtl/display_pkg.sv
// Shared types and helpers for the multiplexed 7-segment scan controller.
package display_pkg;

  localparam logic [3:0] BLANK_CODE = 4'hF;
  localparam int MAX_DIGITS = 8;

  typedef logic [3:0] bcd_t;

  typedef enum logic {
    DEAD,
    DRIVE
  } scan_state_e;

  // Bit i set: digit i is a leading zero to blank.
  function automatic logic [MAX_DIGITS-1:0] lzs_mask(
    input logic [4*MAX_DIGITS-1:0] digits,
    input logic [MAX_DIGITS-1:0]   dp,
    input int                      n
  );
    logic [MAX_DIGITS-1:0] m;
    logic                  lead;
    m    = '0;
    lead = 1'b1;
    for (int i = MAX_DIGITS - 1; i >= 0; i--) begin
      if (i < n) begin
        if (lead && digits[4*i+:4] == 4'd0 && !dp[i] && i != 0)
          m[i] = 1'b1;
        else
          lead = 1'b0;
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Slot counter and digit index for the display scan.
// Emits slot and frame wrap strobes plus the next slot count.
module scan_tick_gen #(
  parameter int TICK_DIV = 50000,
  parameter int N_DIGITS = 4,
  parameter int CW       = $clog2(TICK_DIV),
  parameter int IW       = $clog2(N_DIGITS)
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic [CW-1:0] cnt_nxt_o,
  output logic [IW-1:0] idx_o,
  output logic          slot_wrap_o,
  output logic          frame_wrap_o
);

  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(N_DIGITS - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          slot_wrap;

  always_comb begin
    slot_wrap = (cnt_q == CNT_LAST);
    cnt_d     = slot_wrap ? '0 : cnt_q + 1'b1;
    idx_d     = idx_q;
    if (slot_wrap)
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

  assign cnt_nxt_o    = cnt_d;
  assign idx_o        = idx_q;
  assign slot_wrap_o  = slot_wrap;
  assign frame_wrap_o = slot_wrap && (idx_q == IDX_LAST);

endmodule

// File: rtl/display_scan_ctrl.sv
// Multiplexed BCD display scanner with frame-synchronous double buffer.
// Define DISPLAY_DIMMING_EN to add the bright_i PWM dimming input.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int N_DIGITS      = 4,
  parameter int TICK_DIV      = 50000,
  parameter int DEAD_CYCLES   = 500,
  parameter int AN_ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [4*N_DIGITS-1:0] in_digits_i,
  input  logic [N_DIGITS-1:0]   in_dp_i,
  input  logic                  in_lzs_i,
`ifdef DISPLAY_DIMMING_EN
  input  logic [3:0]            bright_i,
`endif
  output logic [3:0]            seg_data_o,
  output logic                  seg_dp_o,
  output logic [N_DIGITS-1:0]   an_o,
  output logic                  frame_done_o
);

  localparam int CW = $clog2(TICK_DIV);
  localparam int IW = $clog2(N_DIGITS);
  localparam logic [CW-1:0] DEAD_C = CW'(DEAD_CYCLES);
  localparam logic [N_DIGITS-1:0] AN_OFF =
    (AN_ACTIVE_LOW != 0) ? '1 : '0;

  logic [CW-1:0] cnt_nxt;
  logic [IW-1:0] idx_q;
  logic          slot_wrap;
  logic          frame_wrap;

  scan_tick_gen #(
    .TICK_DIV (TICK_DIV),
    .N_DIGITS (N_DIGITS),
    .CW       (CW),
    .IW       (IW)
  ) u_tick (
    .clk          (clk),
    .rst_n        (rst_n),
    .cnt_nxt_o    (cnt_nxt),
    .idx_o        (idx_q),
    .slot_wrap_o  (slot_wrap),
    .frame_wrap_o (frame_wrap)
  );

  logic                       run_q;
  logic                       pend_q, pend_d;
  bcd_t [N_DIGITS-1:0]        sh_dig_q;
  logic [N_DIGITS-1:0]        sh_dp_q;
  logic                       sh_lzs_q;
  bcd_t [N_DIGITS-1:0]        act_q, act_new;
  logic [N_DIGITS-1:0]        act_dp_q;
  logic [4*MAX_DIGITS-1:0]    dig_pad;
  logic [MAX_DIGITS-1:0]      dp_pad;
  logic [N_DIGITS-1:0]        mask;
  logic                       accept;
  logic                       commit;

  assign in_ready_o = rst_n & run_q & ~pend_q;
  assign accept     = in_valid_i & in_ready_o;
  assign commit     = frame_wrap & pend_q;

  always_comb begin
    pend_d = pend_q;
    if (accept)
      pend_d = 1'b1;
    else if (commit)
      pend_d = 1'b0;
  end

  // Blanking is resolved once at commit so the scan path is a plain mux.
  always_comb begin
    dig_pad = '0;
    dp_pad  = '0;
    dig_pad[4*N_DIGITS-1:0] = sh_dig_q;
    dp_pad[N_DIGITS-1:0]    = sh_dp_q;
    mask = N_DIGITS'(lzs_mask(dig_pad, dp_pad, N_DIGITS));
    for (int i = 0; i < N_DIGITS; i++)
      act_new[i] = (sh_lzs_q && mask[i]) ? BLANK_CODE : sh_dig_q[i];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      run_q    <= 1'b0;
      pend_q   <= 1'b0;
      sh_dig_q <= '0;
      sh_dp_q  <= '0;
      sh_lzs_q <= 1'b0;
      act_q    <= {N_DIGITS{BLANK_CODE}};
      act_dp_q <= '0;
    end else begin
      run_q  <= 1'b1;
      pend_q <= pend_d;
      if (accept) begin
        sh_dig_q <= in_digits_i;
        sh_dp_q  <= in_dp_i;
        sh_lzs_q <= in_lzs_i;
      end
      if (commit) begin
        act_q    <= act_new;
        act_dp_q <= sh_dp_q;
      end
    end
  end

  logic dim_on;
`ifdef DISPLAY_DIMMING_EN
  logic [3:0] pwm_q;
  always_ff @(posedge clk) begin
    if (!rst_n)
      pwm_q <= '0;
    else
      pwm_q <= pwm_q + 4'd1;
  end
  assign dim_on = (pwm_q <= bright_i);
`else
  assign dim_on = 1'b1;
`endif

  scan_state_e state_q, state_d;

  always_ff @(posedge clk) begin
    if (!rst_n)
      state_q <= (DEAD_CYCLES == 0) ? DRIVE : DEAD;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      DEAD:  if (cnt_nxt >= DEAD_C) state_d = DRIVE;
      DRIVE: if (slot_wrap && DEAD_CYCLES != 0) state_d = DEAD;
      default: state_d = DEAD;
    endcase
  end

  logic [N_DIGITS-1:0] an_q, an_d, sel;
  logic [3:0]          seg_q, seg_d;
  logic                dp_q, dp_d;
  logic                fd_q;

  always_comb begin
    sel        = '0;
    sel[idx_q] = 1'b1;
    an_d       = AN_OFF;
    seg_d      = seg_q;
    dp_d       = dp_q;
    if (state_q == DRIVE) begin
      seg_d = act_q[idx_q];
      dp_d  = act_dp_q[idx_q];
      if (dim_on)
        an_d = (AN_ACTIVE_LOW != 0) ? ~sel : sel;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      an_q  <= AN_OFF;
      seg_q <= BLANK_CODE;
      dp_q  <= 1'b0;
      fd_q  <= 1'b0;
    end else begin
      an_q  <= an_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
      fd_q  <= frame_wrap;
    end
  end

  assign an_o         = an_q;
  assign seg_data_o   = seg_q;
  assign seg_dp_o     = dp_q;
  assign frame_done_o = fd_q;

endmodule
